// File: rtl/minbd_inject.sv
// MinBD local injection unit: queues core flits in a small FIFO and drops the
// head into the first empty slot of the two registered router lanes.
module minbd_inject #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       inj_valid,
    input  logic [8:0]                 inj_flit,
    output logic                       inj_ready,
    input  logic [10:0]                lane1_in,
    input  logic [10:0]                lane2_in,
    output logic [10:0]                lane1_out,
    output logic [10:0]                lane2_out,
    output logic                       inj_fire,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       starve
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = 8;

    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          starve_q, starve_d;
    logic [10:0]   lane1_q, lane1_d;
    logic [10:0]   lane2_q, lane2_d;
    logic          fire_q, fire_d;

    logic          push;
    logic          pop;
    logic          non_empty;
    logic [8:0]    head;

    assign inj_ready  = (count_q < CW'(DEPTH));
    assign push       = inj_valid && inj_ready;
    assign non_empty  = (count_q != '0);
    assign head       = mem_q[rd_ptr_q];

    assign lane1_out  = lane1_q;
    assign lane2_out  = lane2_q;
    assign inj_fire   = fire_q;
    assign fifo_count = count_q;
    assign starve     = starve_q;

    // Slot selection, FIFO bookkeeping and starvation tracking
    always_comb begin
        lane1_d      = lane1_in;
        lane2_d      = lane2_in;
        fire_d       = 1'b0;
        pop          = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        starve_cnt_d = starve_cnt_q;

        if (non_empty && (lane1_in[10:9] == 2'b00)) begin
            lane1_d = {2'b01, head};
            fire_d  = 1'b1;
            pop     = 1'b1;
        end else if (non_empty && (lane2_in[10:9] == 2'b00)) begin
            lane2_d = {2'b01, head};
            fire_d  = 1'b1;
            pop     = 1'b1;
        end

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (fire_d || !non_empty) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != SW'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
        starve_d = (starve_cnt_d == SW'(STARVE_LIMIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
            lane1_q      <= '0;
            lane2_q      <= '0;
            fire_q       <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
            lane1_q      <= lane1_d;
            lane2_q      <= lane2_d;
            fire_q       <= fire_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= inj_flit;
    end

endmodule

// File: tb/tb_minbd_inject.sv
// Bench for minbd_inject: directed scenarios plus a randomized run, all checked
// against a queue-based model of the injection rules.
module tb_minbd_inject;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 15;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          inj_valid = 1'b0;
    logic [8:0]    inj_flit = '0;
    logic          inj_ready;
    logic [10:0]   lane1_in = '0;
    logic [10:0]   lane2_in = '0;
    logic [10:0]   lane1_out;
    logic [10:0]   lane2_out;
    logic          inj_fire;
    logic [CW-1:0] fifo_count;
    logic          starve;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    logic [8:0]  mq[$];
    int          ms = 0;
    logic [10:0] exp_l1 = '0, exp_l2 = '0;
    logic        exp_fire = 1'b0, exp_ready = 1'b1;
    logic        got_ready;

    minbd_inject #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inj_valid  (inj_valid),
        .inj_flit   (inj_flit),
        .inj_ready  (inj_ready),
        .lane1_in   (lane1_in),
        .lane2_in   (lane2_in),
        .lane1_out  (lane1_out),
        .lane2_out  (lane2_out),
        .inj_fire   (inj_fire),
        .fifo_count (fifo_count),
        .starve     (starve)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        ms        = 0;
        exp_l1    = '0;
        exp_l2    = '0;
        exp_fire  = 1'b0;
        exp_ready = 1'b1;
    endtask

    // Drive one cycle from a negedge, advance the model, return at the next negedge
    task automatic cycle(input logic v, input logic [8:0] f,
                         input logic [10:0] l1, input logic [10:0] l2);
        int lane_sel;
        int size_before;
        inj_valid = v;
        inj_flit  = f;
        lane1_in  = l1;
        lane2_in  = l2;
        #1;
        got_ready   = inj_ready;
        size_before = mq.size();
        exp_ready   = (size_before < DEPTH);
        lane_sel    = 0;
        if (size_before > 0) begin
            if (l1[10:9] == 2'b00)      lane_sel = 1;
            else if (l2[10:9] == 2'b00) lane_sel = 2;
        end
        exp_l1   = (lane_sel == 1) ? {2'b01, mq[0]} : l1;
        exp_l2   = (lane_sel == 2) ? {2'b01, mq[0]} : l2;
        exp_fire = (lane_sel != 0);
        if (lane_sel != 0) void'(mq.pop_front());
        if (lane_sel != 0 || size_before == 0) ms = 0;
        else if (ms < LIMIT) ms = ms + 1;
        if (v && exp_ready) mq.push_back(f);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [10:0] rand_lane();
        logic [10:0] x;
        x = 11'($urandom);
        if ($urandom_range(0, 1) == 1) x[10:9] = 2'b00;
        return x;
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        inj_valid = 1'b1;
        inj_flit  = 9'h1FF;
        lane1_in  = '0;
        lane2_in  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        n_vec++; if (lane1_out !== 11'h000) begin n_err++; $display("FAIL reset_lane1 got %h exp 000", lane1_out); end
        n_vec++; if (lane2_out !== 11'h000) begin n_err++; $display("FAIL reset_lane2 got %h exp 000", lane2_out); end
        n_vec++; if (inj_fire !== 1'b0) begin n_err++; $display("FAIL reset_fire got %b exp 0", inj_fire); end
        n_vec++; if (inj_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", inj_ready); end
        n_vec++; if (fifo_count !== CW'(0)) begin n_err++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        n_vec++; if (starve !== 1'b0) begin n_err++; $display("FAIL reset_starve got %b exp 0", starve); end
        inj_valid = 1'b0;
        rst_n     = 1'b1;
    endtask

    task automatic test_basic();
        cycle(1'b1, 9'h0A5, 11'h000, 11'h000);
        n_vec++; if (fifo_count !== CW'(1)) begin n_err++; $display("FAIL basic_push_count got %0d exp 1", fifo_count); end
        n_vec++; if (inj_fire !== 1'b0) begin n_err++; $display("FAIL basic_no_fallthrough got %b exp 0", inj_fire); end
        cycle(1'b0, 9'h000, 11'h000, 11'h000);
        n_vec++; if (lane1_out !== 11'h2A5) begin n_err++; $display("FAIL basic_lane1 got %h exp 2a5", lane1_out); end
        n_vec++; if (inj_fire !== 1'b1) begin n_err++; $display("FAIL basic_fire got %b exp 1", inj_fire); end
        n_vec++; if (fifo_count !== CW'(0)) begin n_err++; $display("FAIL basic_pop_count got %0d exp 0", fifo_count); end
    endtask

    task automatic test_priority();
        cycle(1'b1, 9'h041, 11'h3C2, 11'h3C2);
        cycle(1'b0, 9'h000, 11'h3C2, 11'h000);
        n_vec++; if (lane1_out !== 11'h3C2) begin n_err++; $display("FAIL prio_golden_kept got %h exp 3c2", lane1_out); end
        n_vec++; if (lane2_out !== 11'h241) begin n_err++; $display("FAIL prio_lane2_inj got %h exp 241", lane2_out); end
        cycle(1'b1, 9'h041, 11'h3C2, 11'h3C2);
        cycle(1'b0, 9'h000, 11'h000, 11'h000);
        n_vec++; if (lane1_out !== 11'h241) begin n_err++; $display("FAIL prio_lane1_first got %h exp 241", lane1_out); end
        n_vec++; if (lane2_out !== 11'h000) begin n_err++; $display("FAIL prio_lane2_idle got %h exp 000", lane2_out); end
    endtask

    task automatic test_full_order();
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 9'(i), 11'h200, 11'h200);
            n_vec++; if (fifo_count !== CW'(i)) begin n_err++; $display("FAIL full_fill_count got %0d exp %0d", fifo_count, i); end
        end
        n_vec++; if (inj_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b exp 0", inj_ready); end
        cycle(1'b1, 9'h005, 11'h200, 11'h200);
        n_vec++; if (fifo_count !== CW'(4)) begin n_err++; $display("FAIL full_reject got %0d exp 4", fifo_count); end
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 9'h000, 11'h200, 11'h000);
            n_vec++; if (lane2_out !== (11'h200 | 11'(i))) begin n_err++; $display("FAIL full_order got %h exp %h", lane2_out, 11'h200 | 11'(i)); end
            n_vec++; if (lane1_out !== 11'h200) begin n_err++; $display("FAIL full_lane1_pass got %h exp 200", lane1_out); end
        end
        n_vec++; if (fifo_count !== CW'(0)) begin n_err++; $display("FAIL full_drained got %0d exp 0", fifo_count); end
    endtask

    task automatic test_simul();
        cycle(1'b1, 9'h011, 11'h200, 11'h200);
        cycle(1'b1, 9'h022, 11'h200, 11'h200);
        cycle(1'b1, 9'h077, 11'h000, 11'h200);
        n_vec++; if (fifo_count !== CW'(2)) begin n_err++; $display("FAIL simul_count got %0d exp 2", fifo_count); end
        n_vec++; if (lane1_out !== 11'h211) begin n_err++; $display("FAIL simul_head got %h exp 211", lane1_out); end
        cycle(1'b0, 9'h000, 11'h000, 11'h200);
        n_vec++; if (lane1_out !== 11'h222) begin n_err++; $display("FAIL simul_second got %h exp 222", lane1_out); end
        cycle(1'b0, 9'h000, 11'h000, 11'h200);
        n_vec++; if (lane1_out !== 11'h277) begin n_err++; $display("FAIL simul_last got %h exp 277", lane1_out); end
        n_vec++; if (fifo_count !== CW'(0)) begin n_err++; $display("FAIL simul_empty got %0d exp 0", fifo_count); end
    endtask

    task automatic test_starve();
        cycle(1'b1, 9'h033, 11'h200, 11'h200);
        for (int k = 1; k <= 20; k++) begin
            cycle(1'b0, 9'h000, 11'h200, 11'h200);
            n_vec++; if (starve !== (k >= 15)) begin n_err++; $display("FAIL starve_cycle%0d got %b exp %b", k, starve, k >= 15); end
        end
        cycle(1'b0, 9'h000, 11'h000, 11'h200);
        n_vec++; if (lane1_out !== 11'h233) begin n_err++; $display("FAIL starve_inject got %h exp 233", lane1_out); end
        n_vec++; if (starve !== 1'b0) begin n_err++; $display("FAIL starve_clear got %b exp 0", starve); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 9'h0C0 + 9'(i), 11'h200, 11'h200);
        n_vec++; if (fifo_count !== CW'(3)) begin n_err++; $display("FAIL arst_pre_count got %0d exp 3", fifo_count); end
        inj_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++; if (fifo_count !== CW'(0)) begin n_err++; $display("FAIL arst_count got %0d exp 0", fifo_count); end
        n_vec++; if (lane1_out !== 11'h000 || lane2_out !== 11'h000) begin n_err++; $display("FAIL arst_lanes got %h/%h exp 000/000", lane1_out, lane2_out); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 9'h000, 11'h000, 11'h000);
            n_vec++; if (inj_fire !== 1'b0 || lane1_out !== 11'h000) begin n_err++; $display("FAIL arst_stale got fire=%b lane1=%h exp 0/000", inj_fire, lane1_out); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 2) != 0), 9'($urandom), rand_lane(), rand_lane());
            n_vec++; if (got_ready !== exp_ready) begin n_err++; $display("FAIL rand_ready got %b exp %b", got_ready, exp_ready); end
            n_vec++; if (lane1_out !== exp_l1) begin n_err++; $display("FAIL rand_lane1 got %h exp %h", lane1_out, exp_l1); end
            n_vec++; if (lane2_out !== exp_l2) begin n_err++; $display("FAIL rand_lane2 got %h exp %h", lane2_out, exp_l2); end
            n_vec++; if (inj_fire !== exp_fire) begin n_err++; $display("FAIL rand_fire got %b exp %b", inj_fire, exp_fire); end
            n_vec++; if (fifo_count !== CW'(mq.size())) begin n_err++; $display("FAIL rand_count got %0d exp %0d", fifo_count, mq.size()); end
            n_vec++; if (starve !== (ms == LIMIT)) begin n_err++; $display("FAIL rand_starve got %b exp %b", starve, ms == LIMIT); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_priority();
        test_full_order();
        test_simul();
        test_starve();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
